// File: rtl/cpu_mc.sv
// Multi-cycle CPU control core: sequences FETCH -> DECODE -> EXEC -> (MEM) -> WB
// and owns PC, ir and npc. Decode and ALU live outside; their flags are sampled here.
// Optional build macro CPU_MC_PERF_EN adds the instret/cycles performance counters.
// Without it both counter outputs are tied to zero.
module cpu_mc #(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic [PC_W-1:0]    PC,
    output logic [PC_W-1:0]    npc,
    input  logic               is_mem,
    input  logic               is_halt,
    input  logic               br_take,
    input  logic [PC_W-1:0]    br_target,
    output logic               dec_en,
    output logic               ex_en,
    output logic               wb_en,
    output logic               dmem_req,
    input  logic               dmem_ack,
    output logic               halted,
    output logic [31:0]        instret,
    output logic [31:0]        cycles
);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    npc_q, npc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    // Cleared by reset: keeps the fetch request low for the first cycle after
    // reset is released, so a reset always abandons any outstanding access.
    logic               active_q;

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StFetch;
            active_q <= 1'b0;
            pc_q     <= RESET_PC;
            npc_q    <= '0;
            ir_q     <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= 1'b1;
            pc_q     <= pc_d;
            npc_q    <= npc_d;
            ir_q     <= ir_d;
        end
    end

    // Next-state and datapath update; inputs only matter in the state that samples them.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        ir_d    = ir_q;
        unique case (state_q)
            StFetch: begin
                if (active_q && imem_ack) begin
                    ir_d    = imem_rdata;
                    npc_d   = pc_q + PC_W'(4);
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = is_halt ? StHalt : StExec;
            end
            StExec: begin
                state_d = is_mem ? StMem : StWb;
            end
            StMem: begin
                if (dmem_ack) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                // Branch targets are forced word-aligned.
                pc_d    = br_take ? (br_target & ~PC_W'(3)) : npc_q;
                state_d = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // Control outputs decoded purely from registered state.
    always_comb begin
        imem_req = active_q && (state_q == StFetch);
        dec_en   = (state_q == StDecode);
        ex_en    = (state_q == StExec);
        dmem_req = (state_q == StMem);
        wb_en    = (state_q == StWb);
        halted   = (state_q == StHalt);
    end

    assign imem_addr = pc_q;
    assign PC        = pc_q;
    assign npc       = npc_q;
    assign ir        = ir_q;

`ifdef CPU_MC_PERF_EN
    logic [31:0] instret_q;
    logic [31:0] cycles_q;
    logic        retire;

    // An instruction retires in its single WB cycle.
    assign retire = (state_q == StWb);

    // Free-running counters, wrapping modulo 2^32; cycles also runs while halted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            instret_q <= '0;
            cycles_q  <= '0;
        end else begin
            cycles_q <= cycles_q + 32'd1;
            if (retire) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign instret = instret_q;
    assign cycles  = cycles_q;
`else
    assign instret = '0;
    assign cycles  = '0;
`endif

endmodule

// File: tb/tb_cpu_mc.sv
// Self-checking bench for cpu_mc: scripted and random instruction sequences
// checked against a transaction-level model of PC flow, latency and counters.
module tb_cpu_mc;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [31:0] PC;
    logic [31:0] npc;
    logic        is_mem;
    logic        is_halt;
    logic        br_take;
    logic [31:0] br_target;
    logic        dec_en;
    logic        ex_en;
    logic        wb_en;
    logic        dmem_req;
    logic        dmem_ack;
    logic        halted;
    logic [31:0] instret;
    logic [31:0] cycles;

    cpu_mc #(
        .PC_W    (32),
        .INSTR_W (32),
        .RESET_PC(RST_PC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .ir        (ir),
        .PC        (PC),
        .npc       (npc),
        .is_mem    (is_mem),
        .is_halt   (is_halt),
        .br_take   (br_take),
        .br_target (br_target),
        .dec_en    (dec_en),
        .ex_en     (ex_en),
        .wb_en     (wb_en),
        .dmem_req  (dmem_req),
        .dmem_ack  (dmem_ack),
        .halted    (halted),
        .instret   (instret),
        .cycles    (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    // Reference model state
    logic [31:0] exp_pc;
    logic [31:0] exp_ir;
    logic [31:0] exp_npc;
    logic [31:0] m_instret;
    logic [31:0] m_cycles = 0;
    longint      tb_cyc = 0;

    // Counts rising edges seen since the last reset edge.
    always @(posedge clk) begin
        tb_cyc <= tb_cyc + 1;
        if (!rst) m_cycles <= 0;
        else      m_cycles <= m_cycles + 1;
    end

    function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef CPU_MC_PERF_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    // Randomise every input whose value should not matter this cycle.
    task automatic noise();
        imem_ack   = 1'($urandom_range(0, 1));
        dmem_ack   = 1'($urandom_range(0, 1));
        is_mem     = 1'($urandom_range(0, 1));
        is_halt    = 1'($urandom_range(0, 1));
        br_take    = 1'($urandom_range(0, 1));
        br_target  = $urandom;
        imem_rdata = $urandom;
    endtask

    // Called at a negedge; asserts reset for one edge, checks, releases.
    task automatic do_reset();
        noise();
        rst = 1'b0;
        @(negedge clk);
        exp_pc = RST_PC; exp_ir = 0; exp_npc = 0; m_instret = 0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req: got %b want 0", imem_req); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_dmem_req: got %b want 0", dmem_req); end
        checks++; if (PC !== RST_PC) begin errors++; $display("FAIL rst_pc: got %h want %h", PC, RST_PC); end
        checks++; if (ir !== 32'd0) begin errors++; $display("FAIL rst_ir: got %h want 0", ir); end
        checks++; if (npc !== 32'd0) begin errors++; $display("FAIL rst_npc: got %h want 0", npc); end
        checks++; if ({dec_en, ex_en, wb_en, halted} !== 4'b0) begin errors++; $display("FAIL rst_enables: got %b want 0000", {dec_en, ex_en, wb_en, halted}); end
        checks++; if (instret !== 32'd0 || cycles !== 32'd0) begin errors++; $display("FAIL rst_counters: got %h/%h want 0/0", instret, cycles); end
        noise();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_release_req: got %b want 1", imem_req); end
        checks++; if (cycles !== perf(m_cycles)) begin errors++; $display("FAIL rst_release_cycles: got %h want %h", cycles, perf(m_cycles)); end
    endtask

    // One instruction, starting at the negedge of its first FETCH cycle.
    // id: fetch ack delay; md: mem ack delay; abort_mem >= 0 returns mid-MEM.
    task automatic run_instr(input int id, input bit mem, input int md, input bit bt,
                             input logic [31:0] tgt, input bit halt, input int abort_mem);
        logic [31:0] rd;
        longint      t0;
        int          lat;
        int          want_lat;
        rd = $urandom;
        t0 = tb_cyc;
        for (int k = 0; k <= id; k++) begin
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fetch_req: got %b want 1", imem_req); end
            checks++; if (imem_addr !== exp_pc) begin errors++; $display("FAIL fetch_addr: got %h want %h", imem_addr, exp_pc); end
            checks++; if (ir !== exp_ir) begin errors++; $display("FAIL ir_hold: got %h want %h", ir, exp_ir); end
            noise();
            imem_ack = (k == id);
            if (k == id) imem_rdata = rd;
            @(negedge clk);
        end
        exp_ir  = rd;
        exp_npc = exp_pc + 32'd4;
        checks++; if (dec_en !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL decode_en: got dec_en=%b imem_req=%b want 1/0", dec_en, imem_req); end
        checks++; if (ir !== exp_ir) begin errors++; $display("FAIL ir_capture: got %h want %h", ir, exp_ir); end
        checks++; if (npc !== exp_npc) begin errors++; $display("FAIL npc: got %h want %h", npc, exp_npc); end
        noise();
        is_halt = halt;
        @(negedge clk);
        if (halt) return;
        checks++; if (ex_en !== 1'b1 || dec_en !== 1'b0) begin errors++; $display("FAIL exec_en: got ex_en=%b dec_en=%b want 1/0", ex_en, dec_en); end
        noise();
        is_mem = mem;
        @(negedge clk);
        if (mem) begin
            for (int k = 0; k <= md; k++) begin
                checks++; if (dmem_req !== 1'b1 || wb_en !== 1'b0) begin errors++; $display("FAIL mem_req: got dmem_req=%b wb_en=%b want 1/0", dmem_req, wb_en); end
                if (k == abort_mem) return;
                noise();
                dmem_ack = (k == md);
                @(negedge clk);
            end
        end
        checks++; if (wb_en !== 1'b1 || dmem_req !== 1'b0) begin errors++; $display("FAIL wb_en: got wb_en=%b dmem_req=%b want 1/0", wb_en, dmem_req); end
        noise();
        br_take   = bt;
        br_target = tgt;
        @(negedge clk);
        exp_pc    = bt ? {tgt[31:2], 2'b00} : exp_npc;
        m_instret = m_instret + 1;
        lat       = int'(tb_cyc - t0);
        want_lat  = id + 4 + (mem ? md + 1 : 0);
        checks++; if (imem_req !== 1'b1 || PC !== exp_pc) begin errors++; $display("FAIL next_pc: got req=%b pc=%h want 1/%h", imem_req, PC, exp_pc); end
        checks++; if (lat !== want_lat) begin errors++; $display("FAIL latency: got %0d want %0d", lat, want_lat); end
        checks++; if (instret !== perf(m_instret)) begin errors++; $display("FAIL instret: got %h want %h", instret, perf(m_instret)); end
        checks++; if (cycles !== perf(m_cycles)) begin errors++; $display("FAIL cycles: got %h want %h", cycles, perf(m_cycles)); end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_reset_pc();
        run_instr(0, 1'b0, 0, 1'b0, 32'h0, 1'b0, -1);
        checks++; if (PC !== 32'h104) begin errors++; $display("FAIL reset_pc_next: got %h want 00000104", PC); end
    endtask

    task automatic test_fetch_wait();
        run_instr(3, 1'b0, 0, 1'b0, 32'h0, 1'b0, -1);
    endtask

    task automatic test_mem_wait();
        run_instr(0, 1'b1, 2, 1'b0, 32'h0, 1'b0, -1);
    endtask

    task automatic test_branch();
        run_instr(0, 1'b0, 0, 1'b1, 32'h203, 1'b0, -1);
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL branch_addr: got %h want 00000200", imem_addr); end
        run_instr(1, 1'b1, 0, 1'b1, 32'hFFFF_FFFF, 1'b0, -1);
        run_instr(0, 1'b0, 0, 1'b0, 32'h0, 1'b0, -1);
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL pc_wrap: got %h want 00000000", PC); end
    endtask

    task automatic test_halt();
        run_instr(0, 1'b0, 0, 1'b0, 32'h0, 1'b1, -1);
        for (int k = 0; k < 6; k++) begin
            checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL halt_state: got halted=%b imem_req=%b want 1/0", halted, imem_req); end
            checks++; if ({dec_en, ex_en, wb_en, dmem_req} !== 4'b0) begin errors++; $display("FAIL halt_enables: got %b want 0000", {dec_en, ex_en, wb_en, dmem_req}); end
            checks++; if (PC !== exp_pc || ir !== exp_ir) begin errors++; $display("FAIL halt_frozen: got pc=%h ir=%h want %h/%h", PC, ir, exp_pc, exp_ir); end
            checks++; if (cycles !== perf(m_cycles) || instret !== perf(m_instret)) begin errors++; $display("FAIL halt_counters: got %h/%h want %h/%h", cycles, instret, perf(m_cycles), perf(m_instret)); end
            noise();
            @(negedge clk);
        end
        do_reset();
        run_instr(0, 1'b0, 0, 1'b0, 32'h0, 1'b0, -1);
    endtask

    task automatic test_reset_mid_fetch();
        noise();
        imem_ack = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL midfetch_req: got %b want 1", imem_req); end
        do_reset();
        run_instr(1, 1'b0, 0, 1'b0, 32'h0, 1'b0, -1);
    endtask

    task automatic test_reset_mid_mem();
        run_instr(0, 1'b1, 5, 1'b0, 32'h0, 1'b0, 2);
        do_reset();
        for (int k = 0; k < 3; k++) run_instr(k, k[0], k, 1'b0, 32'h0, 1'b0, -1);
        checks++; if (instret !== perf(32'd3)) begin errors++; $display("FAIL instret_after_3: got %h want %h", instret, perf(32'd3)); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            run_instr(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      $urandom, 1'b0, -1);
        end
    endtask

    initial begin
        rst = 1'b0;
        noise();
        @(negedge clk);
        test_reset();
        test_reset_pc();
        test_fetch_wait();
        test_mem_wait();
        test_branch();
        test_reset_mid_fetch();
        test_reset_mid_mem();
        test_random();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
